guess_entry: RTL and testbench

- Upstream front-end for the hangman control unit. Turns raw board inputs into one clean, single-cycle guess event per button press.
- Inputs: a letter code on switches and a bouncy active-low commit pushbutton.
- Synchronises and debounces the button, range-checks the code and filters repeated letters against a per-game guessed-letter map.
- Only accepted guesses reach the control unit; rejects are flagged to the LEDs.

---
 rtl/hangman_pkg.sv | 17 +
 rtl/key_debouncer.sv | 75 +++++++
 rtl/guess_entry.sv | 123 ++++++++++++
 tb/tb_guess_entry.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/hangman_pkg.sv
// rtl/hangman_pkg.sv - shared letter codes and guess-entry FSM state type
package hangman_pkg;

  localparam logic [5:0] LETTER_A    = 6'h0A;
  localparam logic [5:0] LETTER_Z    = 6'h23;
  localparam logic [5:0] DASH        = 6'h00;
  localparam int         NUM_LETTERS = 26;

  typedef enum logic [2:0] {
    IDLE,
    PRESS_DB,
    CHECK,
    WAIT_REL,
    REL_DB
  } ge_state_e;

endpackage

// File: rtl/key_debouncer.sv
// rtl/key_debouncer.sv - commit key synchroniser, press/release debounce FSM, one-cycle press event
module key_debouncer
  import hangman_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic resetn,
  input  logic key_n,
  input  logic clear,
  output logic press_evt,
  output logic busy
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          key_meta_q, key_s_q;
  ge_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      key_meta_q <= 1'b1;
      key_s_q    <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= '0;
    end else begin
      key_meta_q <= key_n;
      key_s_q    <= key_meta_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (!key_s_q) begin
          state_d = PRESS_DB;
          cnt_d   = '0;
        end
      end
      PRESS_DB: begin
        if (key_s_q)                state_d = IDLE;
        else if (cnt_q == CNT_LAST) state_d = CHECK;
        else                        cnt_d   = cnt_q + CW'(1);
      end
      CHECK: state_d = WAIT_REL;
      WAIT_REL: begin
        if (key_s_q) begin
          state_d = REL_DB;
          cnt_d   = '0;
        end
      end
      REL_DB: begin
        if (!key_s_q)               state_d = WAIT_REL;
        else if (cnt_q == CNT_LAST) state_d = IDLE;
        else                        cnt_d   = cnt_q + CW'(1);
      end
      default: state_d = IDLE;
    endcase
    // A key still held through clear must be released before it can count again
    if (clear) begin
      state_d = key_s_q ? IDLE : WAIT_REL;
      cnt_d   = '0;
    end
  end

  assign press_evt = (state_q == CHECK) && !clear;
  assign busy      = (state_q != IDLE);

endmodule

// File: rtl/guess_entry.sv
// rtl/guess_entry.sv - hangman guess front-end; GUESS_ENTRY_DUP_FILTER_EN enables the repeat-letter filter
module guess_entry
  import hangman_pkg::*;
#(
  parameter int         DEBOUNCE_CYCLES = 1000000,
  parameter logic [5:0] CODE_MIN        = LETTER_A,
  parameter logic [5:0] CODE_MAX        = LETTER_Z
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [5:0]             sw_code,
  input  logic                   key_n,
  input  logic                   clear,
  output logic [5:0]             guess_code,
  output logic                   guess_strobe,
  output logic                   reject_range,
  output logic                   reject_dup,
  output logic [NUM_LETTERS-1:0] guessed_map,
  output logic                   busy
);

  logic       press_evt;
  logic [5:0] code_meta_q, code_s_q;
  logic [5:0] code_q, code_d;
  logic       strobe_q, strobe_d;
  logic       range_q, range_d;
  logic       in_range;
  logic       is_dup;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debouncer (
    .clk      (clk),
    .resetn   (resetn),
    .key_n    (key_n),
    .clear    (clear),
    .press_evt(press_evt),
    .busy     (busy)
  );

  assign in_range = (code_s_q >= CODE_MIN) && (code_s_q <= CODE_MAX);

`ifdef GUESS_ENTRY_DUP_FILTER_EN
  localparam logic [NUM_LETTERS-1:0] MAP_ONE = {{(NUM_LETTERS-1){1'b0}}, 1'b1};

  logic [NUM_LETTERS-1:0] map_q, map_d, map_mask;
  logic [5:0]             map_idx;
  logic                   dup_q, dup_d;

  // Index only meaningful when in range; out-of-range codes never reach the map
  assign map_idx  = code_s_q - CODE_MIN;
  assign map_mask = MAP_ONE << map_idx;
  assign is_dup   = |(map_q & map_mask);
`else
  assign is_dup = 1'b0;
`endif

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      code_meta_q <= '0;
      code_s_q    <= '0;
      code_q      <= DASH;
      strobe_q    <= 1'b0;
      range_q     <= 1'b0;
`ifdef GUESS_ENTRY_DUP_FILTER_EN
      map_q       <= '0;
      dup_q       <= 1'b0;
`endif
    end else begin
      code_meta_q <= sw_code;
      code_s_q    <= code_meta_q;
      code_q      <= code_d;
      strobe_q    <= strobe_d;
      range_q     <= range_d;
`ifdef GUESS_ENTRY_DUP_FILTER_EN
      map_q       <= map_d;
      dup_q       <= dup_d;
`endif
    end
  end

  always_comb begin
    code_d   = code_q;
    strobe_d = 1'b0;
    range_d  = 1'b0;
`ifdef GUESS_ENTRY_DUP_FILTER_EN
    map_d    = map_q;
    dup_d    = 1'b0;
`endif
    if (clear) begin
      code_d = DASH;
`ifdef GUESS_ENTRY_DUP_FILTER_EN
      map_d  = '0;
`endif
    end else if (press_evt) begin
      if (!in_range) begin
        range_d = 1'b1;
      end else if (is_dup) begin
`ifdef GUESS_ENTRY_DUP_FILTER_EN
        dup_d = 1'b1;
`endif
      end else begin
        strobe_d = 1'b1;
        code_d   = code_s_q;
`ifdef GUESS_ENTRY_DUP_FILTER_EN
        map_d    = map_q | map_mask;
`endif
      end
    end
  end

  assign guess_code   = code_q;
  assign guess_strobe = strobe_q;
  assign reject_range = range_q;
`ifdef GUESS_ENTRY_DUP_FILTER_EN
  assign reject_dup   = dup_q;
  assign guessed_map  = map_q;
`else
  assign reject_dup   = 1'b0;
  assign guessed_map  = '0;
`endif

endmodule

// File: tb/tb_guess_entry.sv
// tb/tb_guess_entry.sv - scoreboard bench for guess_entry with a letter-set reference model
module tb_guess_entry;

  localparam int DB = 4;
`ifdef GUESS_ENTRY_DUP_FILTER_EN
  localparam bit DUP_EN = 1'b1;
`else
  localparam bit DUP_EN = 1'b0;
`endif
  localparam int K_STROBE = 0;
  localparam int K_RANGE  = 1;
  localparam int K_DUP    = 2;

  typedef struct {
    int          kind;
    logic [5:0]  code;
    logic [25:0] map;
    int          edge_n;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic [5:0]  sw_code = 6'h00;
  logic        key_n = 1'b1;
  logic        clear = 1'b0;
  logic [5:0]  guess_code;
  logic        guess_strobe;
  logic        reject_range;
  logic        reject_dup;
  logic [25:0] guessed_map;
  logic        busy;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        q[$];
  logic [25:0] guessed = '0;
  logic [5:0]  last_code = 6'h00;

  guess_entry #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .sw_code     (sw_code),
    .key_n       (key_n),
    .clear       (clear),
    .guess_code  (guess_code),
    .guess_strobe(guess_strobe),
    .reject_range(reject_range),
    .reject_dup  (reject_dup),
    .guessed_map (guessed_map),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: a set of accepted letters; one outcome per press, first edge e samples key low
  task automatic model_press(input logic [5:0] code, input int e);
    exp_t x;
    int   idx;
    if (code < 6'h0A || code > 6'h23) begin
      x.kind = K_RANGE;
    end else begin
      idx = int'(code) - 10;
      if (DUP_EN && ((guessed >> idx) & 26'd1) != 26'd0) begin
        x.kind = K_DUP;
      end else begin
        x.kind    = K_STROBE;
        guessed   = guessed | (26'd1 << idx);
        last_code = code;
      end
    end
    x.code   = last_code;
    x.map    = DUP_EN ? guessed : 26'd0;
    x.edge_n = e + DB + 3;
    q.push_back(x);
  endtask

  task automatic model_wipe();
    guessed   = '0;
    last_code = 6'h00;
  endtask

  always @(negedge clk) begin
    int   np;
    int   act_kind;
    exp_t x;
    if (!resetn) begin
      np = int'(guess_strobe) + int'(reject_range) + int'(reject_dup);
      if (np != 0) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pulse: strobe=%0b range=%0b dup=%0b code=0x%0h, expected no pulse (cycle %0d)",
                   guess_strobe, reject_range, reject_dup, guess_code, cyc);
        end else begin
          x = q.pop_front();
          act_kind = guess_strobe ? K_STROBE : (reject_range ? K_RANGE : K_DUP);
          check("pulse_count", 32'(np), 32'd1);
          check("pulse_kind", 32'(act_kind), 32'(x.kind));
          check("guess_code", 32'(guess_code), 32'(x.code));
          check("guessed_map", 32'(guessed_map), 32'(x.map));
          check("pulse_edge", 32'(cyc), 32'(x.edge_n));
        end
      end
    end
  end

  task automatic press(input logic [5:0] code, input int hold, input logic [5:0] code2, input int chg_at);
    int e;
    @(negedge clk);
    sw_code = code;
    repeat (4) @(negedge clk);
    key_n = 1'b0;
    e = cyc + 1;
    model_press(code, e);
    for (int i = 1; i <= hold; i++) begin
      @(negedge clk);
      if (i == chg_at) sw_code = code2;
    end
    key_n = 1'b1;
    repeat (12) @(negedge clk);
    check("busy_after_release", 32'(busy), 32'd0);
  endtask

  task automatic bounce_press(input logic [5:0] code);
    int e;
    @(negedge clk);
    sw_code = code;
    repeat (4) @(negedge clk);
    key_n = 1'b0;
    repeat (2) @(negedge clk);
    key_n = 1'b1;
    @(negedge clk);
    key_n = 1'b0;
    e = cyc + 1;
    model_press(code, e);
    repeat (20) @(negedge clk);
    key_n = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic clear_while_held();
    int e;
    @(negedge clk);
    sw_code = 6'h11;
    repeat (4) @(negedge clk);
    key_n = 1'b0;
    e = cyc + 1;
    model_press(6'h11, e);
    repeat (20) @(negedge clk);
    clear = 1'b1;
    model_wipe();
    @(negedge clk);
    clear = 1'b0;
    check("clear_code", 32'(guess_code), 32'd0);
    check("clear_map", 32'(guessed_map), 32'd0);
    check("clear_busy_held", 32'(busy), 32'd1);
    repeat (20) @(negedge clk);
    key_n = 1'b1;
    repeat (12) @(negedge clk);
    press(6'h11, 15, 6'h11, 0);
  endtask

  task automatic reset_mid_debounce();
    @(negedge clk);
    sw_code = 6'h12;
    repeat (4) @(negedge clk);
    key_n = 1'b0;
    repeat (4) @(negedge clk);
    check("busy_in_press_db", 32'(busy), 32'd1);
    resetn = 1'b1;
    key_n  = 1'b1;
    model_wipe();
    @(negedge clk);
    resetn = 1'b0;
    check("rst_code", 32'(guess_code), 32'd0);
    check("rst_map", 32'(guessed_map), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    repeat (20) @(negedge clk);
  endtask

  initial begin
    #(50000 * 10);
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached with %0d expected events pending", q.size());
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] c;
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check("reset_code", 32'(guess_code), 32'd0);
    check("reset_map", 32'(guessed_map), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_pulses", 32'({guess_strobe, reject_range, reject_dup}), 32'd0);

    press(6'h1C, 20, 6'h1C, 0);
    bounce_press(6'h15);
    press(6'h1C, 20, 6'h1C, 0);
    press(6'h05, 15, 6'h05, 0);
    press(6'h24, 15, 6'h24, 0);
    press(6'h09, 15, 6'h09, 0);
    press(6'h23, 15, 6'h23, 0);
    press(6'h0A, 100, 6'h0B, 40);
    press(6'h0B, 15, 6'h0B, 0);
    clear_while_held();
    reset_mid_debounce();

    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 3) == 0) c = 6'($urandom_range(0, 63));
      else                           c = 6'(10 + $urandom_range(0, 5));
      press(c, 10 + int'($urandom_range(0, 20)), c, 0);
    end

    repeat (10) @(negedge clk);
    check("queue_empty", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
